// File: rtl/sync_fifo_pkg.sv
// Shared sizing helpers and types for sync_fifo_prog and its scoreboard.
package sync_fifo_pkg;

  function automatic int unsigned addr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // Level and threshold width: one extra bit so that level can reach FIFO_DEPTH.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic overflow;
    logic underflow;
  } fifo_err_t;

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_WR,
    OP_RD,
    OP_RDWR
  } fifo_op_t;

endpackage

// File: rtl/sync_fifo_prog_if.sv
// Producer/consumer bus of sync_fifo_prog; master drives requests, slave is the FIFO.
interface sync_fifo_prog_if
  import sync_fifo_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DATA_WIDTH = 8
);
  localparam int unsigned CNT_W = cnt_w(FIFO_DEPTH);

  logic                  flush;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic [CNT_W-1:0]      af_thresh;
  logic [CNT_W-1:0]      ae_thresh;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CNT_W-1:0]      level;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, wr_en, data_in, rd_en, af_thresh, ae_thresh,
    input  data_out, rd_valid, full, empty, almost_full, almost_empty,
           level, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, data_in, rd_en, af_thresh, ae_thresh,
    output data_out, rd_valid, full, empty, almost_full, almost_empty,
           level, overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_mem.sv
// FIFO storage: synchronous write port, asynchronous read port.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [addr_w(FIFO_DEPTH)-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]         wdata,
  input  logic [addr_w(FIFO_DEPTH)-1:0] raddr,
  output logic [DATA_WIDTH-1:0]         rdata
);

  logic [DATA_WIDTH-1:0] storage [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      storage[waddr] <= wdata;
    end
  end

  assign rdata = storage[raddr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Synchronous FIFO with programmable almost flags, level output, sticky errors and flush.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is registered read.
module sync_fifo_prog
  import sync_fifo_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  sync_fifo_prog_if.slave bus
);

  localparam int unsigned ADDR_W = addr_w(FIFO_DEPTH);
  localparam int unsigned CNT_W  = cnt_w(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_LVL = CNT_W'(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo_prog: FIFO_DEPTH must be a power of 2 and >= 2");
  end

  if ($bits(bus.data_in) != DATA_WIDTH || $bits(bus.level) != CNT_W) begin : g_bad_bus
    $error("sync_fifo_prog: interface parameters do not match the FIFO");
  end

  logic [ADDR_W:0]       wr_ptr;
  logic [ADDR_W:0]       rd_ptr;
  logic [CNT_W-1:0]      level_q;
  fifo_err_t             err_q;
  fifo_err_t             err_d;
  fifo_op_t              op;
  logic                  full_w;
  logic                  empty_w;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Acceptance uses the flags as they stand at the start of the cycle; flush masks both sides.
  always_comb begin
    full_w  = (level_q == DEPTH_LVL);
    empty_w = (level_q == '0);
    wr_acc  = bus.wr_en && !full_w  && !bus.flush;
    rd_acc  = bus.rd_en && !empty_w && !bus.flush;
  end

  always_comb begin
    op = OP_IDLE;
    unique case ({wr_acc, rd_acc})
      2'b10:   op = OP_WR;
      2'b01:   op = OP_RD;
      2'b11:   op = OP_RDWR;
      default: op = OP_IDLE;
    endcase
  end

  always_comb begin
    err_d = err_q;
    if (bus.flush) begin
      err_d = '0;
    end else begin
      if (bus.wr_en && full_w) err_d.overflow  = 1'b1;
      if (bus.rd_en && empty_w) err_d.underflow = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else if (bus.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      unique case (op)
        OP_WR: begin
          wr_ptr  <= wr_ptr + 1'b1;
          level_q <= level_q + 1'b1;
        end
        OP_RD: begin
          rd_ptr  <= rd_ptr + 1'b1;
          level_q <= level_q - 1'b1;
        end
        OP_RDWR: begin
          wr_ptr <= wr_ptr + 1'b1;
          rd_ptr <= rd_ptr + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  sync_fifo_mem #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (bus.data_in),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (mem_rdata)
  );

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is presented directly; rd_en only acknowledges it.
  assign bus.data_out = empty_w ? '0 : mem_rdata;
  assign bus.rd_valid = !empty_w;
`else
  logic [DATA_WIDTH-1:0] data_q;
  logic                  rd_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc;
      if (rd_acc) begin
        data_q <= mem_rdata;
      end
    end
  end

  assign bus.data_out = data_q;
  assign bus.rd_valid = rd_valid_q;
`endif

  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.level        = level_q;
  assign bus.almost_full  = (level_q >= bus.af_thresh);
  assign bus.almost_empty = (level_q <= bus.ae_thresh);
  assign bus.overflow     = err_q.overflow;
  assign bus.underflow    = err_q.underflow;

endmodule

// File: doc/sync_fifo_prog.md
Name: sync_fifo_prog

Overview:
Parametrised next-generation synchronous FIFO with these additions:
- runtime-programmable almost-full/almost-empty thresholds
- fill-level output
- sticky overflow/underflow error flags
- synchronous flush
It buffers DATA_WIDTH-wide words between a producer and a consumer in one clock domain. It replaces the basic single-mode FIFO in datapath glue and in testbench scoreboards.

Parameters:
- FIFO_DEPTH, 16, number of entries; must be a power of 2 and ≥2 (elaboration-time $error otherwise).
- DATA_WIDTH, 8, word width in bits.
- CNT_W, $clog2(FIFO_DEPTH)+1, width of level and threshold ports (derived localparam, not overridable).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of contents and error flags.
- wr_en  in  1  write request.
- data_in  in  DATA_WIDTH  write data.
- rd_en  in  1  read request (read-ack in FWFT mode).
- data_out  out  DATA_WIDTH  read data.
- rd_valid  out  1  data_out holds a newly read word.
- full  out  1  level == FIFO_DEPTH.
- empty  out  1  level == 0.
- af_thresh  in  CNT_W  almost-full threshold.
- ae_thresh  in  CNT_W  almost-empty threshold.
- almost_full  out  1  level ≥ af_thresh.
- almost_empty  out  1  level ≤ ae_thresh.
- level  out  CNT_W  current number of stored words.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.

Behaviour:
- Reset (rst=1, async): pointers, level, data_out, rd_valid, overflow and underflow all go to 0; empty=1, full=0. Storage contents are don't-care.
- Pointers are ADDR_W+1 bits (ADDR_W = $clog2(FIFO_DEPTH)); the low bits index storage and the MSB is the wrap bit. level is a registered counter, not derived from pointers.
- Write accepted iff wr_en && !full, with full sampled at the start of the cycle. Read accepted iff rd_en && !empty, sampled the same way.
- Simultaneous accepted write and read: level is unchanged and both pointers advance.
- Full with wr_en && rd_en: the read is accepted, the write is rejected, and overflow is set. The FIFO is then at FIFO_DEPTH-1.
- Empty with wr_en && rd_en: the write is accepted, the read is rejected, and underflow is set.
- Rejected writes and reads do not change pointers, level or storage.
- level: +1 on write only, -1 on read only, otherwise unchanged. It never exceeds FIFO_DEPTH or goes below 0.
- full, empty, almost_full and almost_empty are combinational from the registered level and threshold inputs. Thresholds may change at any time and take effect the same cycle. af_thresh=0 forces almost_full=1; ae_thresh≥FIFO_DEPTH forces almost_empty=1.
- Standard mode:
  - Read latency is 1: data_out is registered and loaded with storage[rd_ptr] on the edge that accepts a read.
  - rd_valid is 1 for exactly the cycle after an accepted read.
  - data_out holds its value otherwise.
- flush=1 at an edge:
  - rd_ptr, wr_ptr and level go to 0; overflow, underflow and rd_valid are cleared.
  - data_out holds its value.
  - flush overrides wr_en/rd_en in the same cycle: nothing is written, nothing is read, and no error is flagged.
- Pointer wrap: after FIFO_DEPTH accepted writes the wr_ptr low bits return to 0 and the MSB toggles. Ordering is preserved across arbitrary wraps.
- Errors stay set until flush or rst.

Optional Feature:
- Macro SYNC_FIFO_FWFT_EN (first-word-fall-through).
- When defined:
  - data_out = storage[rd_ptr] combinationally whenever !empty.
  - rd_valid = !empty.
  - rd_en acts as an acknowledge that pops the head; the next word appears in the same cycle after the edge.
  - A write into an empty FIFO appears on data_out the cycle after the write edge.
  - The data_out reset value applies only while empty; data_out is don't-care when empty.
- When undefined: standard registered read, latency 1, as above.

Decomposition:
- Package sync_fifo_pkg holds:
  - the function computing CNT_W from depth
  - the localparam-style ADDR_W helper
  - typedef fifo_err_t, a packed struct {overflow, underflow}, shared with the bench scoreboard
- One sub-module, sync_fifo_mem:
  - DATA_WIDTH × FIFO_DEPTH array
  - synchronous write
  - asynchronous read port indexed by rd_ptr low bits
- The top level holds pointers, level, flags, error logic and the output register.

Test Plan:
- Reset then idle: after rst deasserts, empty=1, full=0, level=0, data_out=0, overflow=0, underflow=0.
- Fill/drain with FIFO_DEPTH=8:
  - Write 0x01..0x08: full=1 and level=8 after the 8th edge.
  - A 9th write sets overflow=1 and level stays 8.
  - Read 8 times: data_out is 0x01..0x08 in order, each with rd_valid one cycle after the rd_en edge; then empty=1.
- Simultaneous at boundaries:
  - At level 8, wr_en=rd_en=1 with data 0xAA: level=7, 0xAA is not stored, overflow=1.
  - At level 0, wr_en=rd_en=1 with data 0x55: level=1, underflow=1, and the next read returns 0x55.
- Thresholds: af_thresh=6, ae_thresh=2, write 6 words. almost_empty drops as level goes 2→3 and almost_full rises when level=6. Changing af_thresh to 7 drops almost_full the same cycle.
- Wrap: 3 passes of 8 writes and 8 reads, interleaved at 1 write and 1 read per cycle from level 4. Data order is preserved and level stays 4 throughout.
- Flush mid-stream: at level 5 with overflow set, assert flush together with wr_en=1. Next cycle level=0, empty=1, overflow=0, and the write data is not stored.
